// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer behind uart_controller: captures each completed Rx character
// with its parity flag and hands it to the consumer over a valid/ready handshake.
module uart_rx_fifo #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         rx_done_i,
  input  logic [MAX_UART_DATA_W-1:0]   rx_data_i,
  input  logic                         rx_parity_err_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [MAX_UART_DATA_W-1:0]   m_data_o,
  output logic                         m_parity_err_o,
  output logic [$clog2(FIFO_DEPTH):0]  count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         overflow_o,
  input  logic                         ovf_clr_i
);

  localparam int PtrWidth = $clog2(FIFO_DEPTH);
  localparam logic [PtrWidth:0] DepthCount = (PtrWidth + 1)'(FIFO_DEPTH);

  typedef logic [MAX_UART_DATA_W:0] entry_t;  // {parity_err, data}

  entry_t              mem [FIFO_DEPTH];
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic [PtrWidth:0]   count;
  logic                overflow;

  logic pop;
  logic push_ok;
  logic drop;

  // Status is derived from the registered count only, so rx_done_i never reaches an output.
  assign empty_o    = (count == '0);
  assign full_o     = (count == DepthCount);
  assign m_valid_o  = !empty_o;
  assign count_o    = count;
  assign overflow_o = overflow;

  assign {m_parity_err_o, m_data_o} = mem[rd_ptr];

  // A full FIFO still accepts a character when the head leaves in the same cycle.
  assign pop     = m_valid_o & m_ready_i;
  assign push_ok = rx_done_i & (!full_o | pop);
  assign drop    = rx_done_i & full_o & !pop;

  // NOTE: storage is deliberately not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i && !clr_i) begin
      mem[wr_ptr] <= {rx_parity_err_i, rx_data_i};
    end
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PtrWidth'(1);
      if (pop)     rd_ptr <= rd_ptr + PtrWidth'(1);

      if (push_ok && !pop)      count <= count + (PtrWidth + 1)'(1);
      else if (!push_ok && pop) count <= count - (PtrWidth + 1)'(1);

      // A fresh drop wins over a clear request in the same cycle.
      if (drop)           overflow <= 1'b1;
      else if (ovf_clr_i) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic,
// all compared against a queue-based model of the buffer.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          rx_done = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_perr = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_perr;
  logic [4:0]    count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          ovf_clr = 1'b0;

  uart_rx_fifo #(.MAX_UART_DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clr_i          (clr),
    .rx_done_i      (rx_done),
    .rx_data_i      (rx_data),
    .rx_parity_err_i(rx_perr),
    .m_valid_o      (m_valid),
    .m_ready_i      (m_ready),
    .m_data_o       (m_data),
    .m_parity_err_o (m_perr),
    .count_o        (count),
    .full_o         (full),
    .empty_o        (empty),
    .overflow_o     (overflow),
    .ovf_clr_i      (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW:0] model_q[$];  // {parity_err, data}, head at index 0
  bit          model_ovf = 1'b0;
  bit          model_ok  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Drive one cycle of inputs, compare current outputs with the model, then advance
  // the model by the buffer's rules and step past the next rising edge.
  task automatic cycle(input logic done, input logic [DW-1:0] d, input logic pe,
                       input logic rdy, input logic c = 1'b0, input logic oc = 1'b0,
                       input logic r = 1'b0);
    bit do_pop;
    bit accept;
    rx_done = done; rx_data = d; rx_perr = pe;
    m_ready = rdy; clr = c; ovf_clr = oc; rst = r;
    if (model_ok) begin
      check("count",    32'(count),    32'(model_q.size()));
      check("empty",    32'(empty),    32'(model_q.size() == 0));
      check("full",     32'(full),     32'(model_q.size() == DEPTH));
      check("valid",    32'(m_valid),  32'(model_q.size() != 0));
      check("overflow", 32'(overflow), 32'(model_ovf));
      if (model_q.size() != 0) begin
        check("data", 32'(m_data), 32'(model_q[0][DW-1:0]));
        check("perr", 32'(m_perr), 32'(model_q[0][DW]));
      end
    end
    if (r || c) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else if (model_ok) begin
      do_pop = (model_q.size() != 0) && rdy;
      accept = done && ((model_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(model_q.pop_front());
      if (accept) model_q.push_back({pe, d});
      if (done && !accept) model_ovf = 1'b1;
      else if (oc)         model_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    if (r) model_ok = 1'b1;
    rx_done = 1'b0; m_ready = 1'b0; clr = 1'b0; ovf_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic fill(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) cycle(1'b1, base + DW'(i), 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and reset-state values.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_full",  32'(full), 0);
    check("rst_ovf",   32'(overflow), 0);

    // Three separate pushes while stalled, then back-to-back drain.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, DW'(8'h41 + i), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
    end
    check("abc_count", 32'(count), 3);
    for (int i = 0; i < 3; i++) begin
      check("abc_data", 32'(m_data), 32'(8'h41 + i));
      cycle(1'b0, '0, 1'b0, 1'b1);
    end
    check("abc_empty", 32'(empty), 1);
    check("abc_valid", 32'(m_valid), 0);

    // Fill to depth, drop a 17th character, drain in order.
    fill(DEPTH, 8'h00);
    check("fill_full", 32'(full), 1);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    check("drop_ovf",   32'(overflow), 1);
    check("drop_count", 32'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_seq", 32'(m_data), 32'(i));
      cycle(1'b0, '0, 1'b0, 1'b1);
    end
    check("drain_empty", 32'(empty), 1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_cleared", 32'(overflow), 0);

    // Full with concurrent pop accepts the push.
    fill(DEPTH, 8'h10);
    cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    check("fullpop_count", 32'(count), DEPTH);
    check("fullpop_ovf",   32'(overflow), 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("fullpop_last", 32'(m_data), 32'h AA);
      cycle(1'b0, '0, 1'b0, 1'b1);
    end

    // Parity flag travels with its data.
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    cycle(1'b1, 8'h56, 1'b0, 1'b0);
    check("par1_data", 32'(m_data), 32'h55);
    check("par1_flag", 32'(m_perr), 1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("par0_data", 32'(m_data), 32'h56);
    check("par0_flag", 32'(m_perr), 0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Set wins over clear; clear alone takes effect next cycle.
    fill(DEPTH, 8'h20);
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    check("ovf_set", 32'(overflow), 1);
    cycle(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_set_wins", 32'(overflow), 1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_clr_alone", 32'(overflow), 0);
    cycle(1'b1, 8'h03, 1'b0, 1'b0);
    cycle(1'b1, 8'h04, 1'b0, 1'b1, 1'b1);
    check("clr_count", 32'(count), 0);
    check("clr_empty", 32'(empty), 1);
    check("clr_ovf",   32'(overflow), 0);

    // Wrap-around streaming, then flush and reset each with a concurrent push.
    fill(5, 8'h30);
    for (int i = 0; i < 40; i++) cycle(1'b1, DW'($urandom), 1'(i % 3 == 0), 1'b1);
    check("wrap_count", 32'(count), 5);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
    check("wclr_count", 32'(count), 0);
    check("wclr_empty", 32'(empty), 1);
    check("wclr_ovf",   32'(overflow), 0);
    fill(DEPTH, 8'h40);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b1, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("wrst_count", 32'(count), 0);
    check("wrst_valid", 32'(m_valid), 0);
    check("wrst_ovf",   32'(overflow), 0);

    // Randomized traffic with changing push/pop pressure.
    for (int blk = 0; blk < 20; blk++) begin
      int p_push = $urandom_range(10, 90);
      int p_rdy  = $urandom_range(0, 100);
      for (int i = 0; i < 100; i++) begin
        cycle(1'($urandom_range(0, 99) < p_push), DW'($urandom), 1'($urandom),
              1'($urandom_range(0, 99) < p_rdy),
              1'($urandom_range(0, 199) == 0),
              1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 499) == 0));
      end
    end
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
